register_file: RTL and testbench

- Architectural register file with rename tags; sits directly downstream of the reorder buffer.
- Takes in-order commits from the reorder buffer (RoBRF_* bus) and writes the architectural values.
- Records which RoB entry will produce each register (tag) when the dispatcher issues an instruction.
- Answers the dispatcher's rs1/rs2 operand queries with either a ready value or a RoB dependency index.
- Clears all tags on a misprediction flush.

---
 rtl/register_file.sv | 117 +++++++++++
 tb/tb_register_file.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags. Commits from the reorder
// buffer write values and retire tags. Issues from the dispatcher rename a
// destination to a RoB entry. Operand queries return either a ready value
// or the RoB index that will produce it.
module register_file #(
  parameter int                  REG_WIDTH    = 5,
  parameter int                  EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0] NON_REG  = 6'b100000,
  parameter int                  RoB_WIDTH    = 8,
  parameter int                  EX_RoB_WIDTH = 9,
  parameter logic [EX_RoB_WIDTH-1:0] NON_DEP  = 9'b100000000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    RoBRF_pre_judge,
  input  logic                    RoBRF_en,
  input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  input  logic [31:0]             RoBRF_value,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
  input  logic                    DPRF_en,
  input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
  input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
  output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
  output logic [31:0]             RFDP_Vj,
  output logic [31:0]             RFDP_Vk
);

  localparam int NUM_REGS = 1 << REG_WIDTH;

  logic [31:0]          values [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [RoB_WIDTH-1:0] tags   [NUM_REGS];

  logic [REG_WIDTH-1:0] commit_idx;
  logic [REG_WIDTH-1:0] issue_idx;
  logic                 commit_valid;
  logic                 issue_valid;
  logic                 commit_retires;

  // Decode which commit/issue actually targets a writable register (x0 and
  // the no-register encoding are ignored) and whether the commit retires the
  // current producer of its destination.
  always_comb begin
    commit_idx     = RoBRF_rd[REG_WIDTH-1:0];
    issue_idx      = DPRF_rd[REG_WIDTH-1:0];
    commit_valid   = RoBRF_en && (RoBRF_rd != NON_REG) && (RoBRF_rd != '0);
    issue_valid    = DPRF_en && (DPRF_rd != NON_REG) && (DPRF_rd != '0);
    commit_retires = commit_valid && busy[commit_idx] &&
                     (tags[commit_idx] == RoBRF_RoB_index);
  end

  // State update: reset beats everything; a flush clears every rename but
  // still lets the commit value land; an issue overrides a same-register
  // commit clear because it names a newer producer.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      busy <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        values[i] <= '0;
        tags[i]   <= '0;
      end
    end else if (Sys_rdy) begin
      if (commit_valid) begin
        values[commit_idx] <= RoBRF_value;
      end
      if (!RoBRF_pre_judge) begin
        busy <= '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          tags[i] <= '0;
        end
      end else begin
        if (commit_retires) begin
          busy[commit_idx] <= 1'b0;
        end
        if (issue_valid) begin
          busy[issue_idx] <= 1'b1;
          tags[issue_idx] <= DPRF_RoB_index;
        end
      end
    end
  end

  // Operand lookup shared by both read ports: the commit bypass forwards a
  // value that is retiring this very cycle so the dispatcher never waits on
  // a producer that has already finished.
  function automatic logic [EX_RoB_WIDTH+31:0] lookup(input logic [EX_REG_WIDTH-1:0] rs);
    logic [REG_WIDTH-1:0]    idx;
    logic [EX_RoB_WIDTH-1:0] q;
    logic [31:0]             v;
    idx = rs[REG_WIDTH-1:0];
    q   = NON_DEP;
    v   = '0;
    if ((rs != NON_REG) && (rs != '0)) begin
      if (RoBRF_en && (RoBRF_rd == rs) && busy[idx] &&
          (tags[idx] == RoBRF_RoB_index)) begin
        v = RoBRF_value;
      end else if (busy[idx]) begin
        q = {1'b0, tags[idx]};
        v = values[idx];
      end else begin
        v = values[idx];
      end
    end
    return {q, v};
  endfunction

  // Combinational read ports, evaluated independently per source operand.
  always_comb begin
    {RFDP_Qj, RFDP_Vj} = lookup(DPRF_rs1);
    {RFDP_Qk, RFDP_Vk} = lookup(DPRF_rs2);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, rename/commit with
// bypass, newer-producer commits, same-cycle commit+issue, flush, x0 and
// stall behaviour, and reset discarding same-cycle traffic.
module tb_register_file;

  localparam logic [5:0] NON_REG = 6'b100000;
  localparam logic [8:0] NON_DEP = 9'b100000000;

  logic        Sys_clk;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        RoBRF_pre_judge;
  logic        RoBRF_en;
  logic [7:0]  RoBRF_RoB_index;
  logic [5:0]  RoBRF_rd;
  logic [31:0] RoBRF_value;
  logic [5:0]  DPRF_rs1;
  logic [5:0]  DPRF_rs2;
  logic        DPRF_en;
  logic [5:0]  DPRF_rd;
  logic [7:0]  DPRF_RoB_index;
  logic [8:0]  RFDP_Qj;
  logic [8:0]  RFDP_Qk;
  logic [31:0] RFDP_Vj;
  logic [31:0] RFDP_Vk;

  int checks;
  int errors;

  register_file dut (
    .Sys_clk         (Sys_clk),
    .Sys_rst         (Sys_rst),
    .Sys_rdy         (Sys_rdy),
    .RoBRF_pre_judge (RoBRF_pre_judge),
    .RoBRF_en        (RoBRF_en),
    .RoBRF_RoB_index (RoBRF_RoB_index),
    .RoBRF_rd        (RoBRF_rd),
    .RoBRF_value     (RoBRF_value),
    .DPRF_rs1        (DPRF_rs1),
    .DPRF_rs2        (DPRF_rs2),
    .DPRF_en         (DPRF_en),
    .DPRF_rd         (DPRF_rd),
    .DPRF_RoB_index  (DPRF_RoB_index),
    .RFDP_Qj         (RFDP_Qj),
    .RFDP_Qk         (RFDP_Qk),
    .RFDP_Vj         (RFDP_Vj),
    .RFDP_Vk         (RFDP_Vk)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    Sys_clk = 1'b0;
    forever #5 Sys_clk = ~Sys_clk;
  end

  // Advance past the next rising edge so inputs change away from it.
  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic idle();
    Sys_rst         = 1'b0;
    Sys_rdy         = 1'b1;
    RoBRF_pre_judge = 1'b1;
    RoBRF_en        = 1'b0;
    RoBRF_RoB_index = '0;
    RoBRF_rd        = NON_REG;
    RoBRF_value     = '0;
    DPRF_en         = 1'b0;
    DPRF_rd         = NON_REG;
    DPRF_RoB_index  = '0;
    DPRF_rs1        = NON_REG;
    DPRF_rs2        = NON_REG;
  endtask

  task automatic commit(input logic [5:0] rd, input logic [7:0] idx, input logic [31:0] val);
    RoBRF_en        = 1'b1;
    RoBRF_rd        = rd;
    RoBRF_RoB_index = idx;
    RoBRF_value     = val;
  endtask

  task automatic issue(input logic [5:0] rd, input logic [7:0] idx);
    DPRF_en        = 1'b1;
    DPRF_rd        = rd;
    DPRF_RoB_index = idx;
  endtask

  task automatic test_reset();
    DPRF_rs1 = 6'd3;
    DPRF_rs2 = NON_REG;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP) begin errors++; $display("[TB] FAIL reset_qj: got %h expected %h", RFDP_Qj, NON_DEP); end
    checks++;
    if (RFDP_Vj !== 32'd0) begin errors++; $display("[TB] FAIL reset_vj: got %h expected 0", RFDP_Vj); end
    checks++;
    if (RFDP_Qk !== NON_DEP) begin errors++; $display("[TB] FAIL reset_qk: got %h expected %h", RFDP_Qk, NON_DEP); end
    checks++;
    if (RFDP_Vk !== 32'd0) begin errors++; $display("[TB] FAIL reset_vk: got %h expected 0", RFDP_Vk); end
  endtask

  task automatic test_issue_commit();
    idle();
    issue(6'd5, 8'd7);
    tick();
    idle();
    DPRF_rs1 = 6'd5;
    #1;
    checks++;
    if (RFDP_Qj !== 9'd7) begin errors++; $display("[TB] FAIL issue_qj: got %h expected %h", RFDP_Qj, 9'd7); end
    commit(6'd5, 8'd7, 32'h1234);
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP) begin errors++; $display("[TB] FAIL bypass_qj: got %h expected %h", RFDP_Qj, NON_DEP); end
    checks++;
    if (RFDP_Vj !== 32'h1234) begin errors++; $display("[TB] FAIL bypass_vj: got %h expected 1234", RFDP_Vj); end
    tick();
    idle();
    DPRF_rs1 = 6'd5;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP) begin errors++; $display("[TB] FAIL retired_qj: got %h expected %h", RFDP_Qj, NON_DEP); end
    checks++;
    if (RFDP_Vj !== 32'h1234) begin errors++; $display("[TB] FAIL retired_vj: got %h expected 1234", RFDP_Vj); end
  endtask

  task automatic test_newer_producer();
    idle();
    issue(6'd6, 8'd2);
    tick();
    issue(6'd6, 8'd9);
    tick();
    idle();
    commit(6'd6, 8'd2, 32'hAA);
    DPRF_rs1 = 6'd6;
    #1;
    checks++;
    if (RFDP_Qj !== 9'd9) begin errors++; $display("[TB] FAIL stale_commit_qj: got %h expected %h", RFDP_Qj, 9'd9); end
    tick();
    idle();
    DPRF_rs1 = 6'd6;
    #1;
    checks++;
    if (RFDP_Qj !== 9'd9) begin errors++; $display("[TB] FAIL newer_tag_qj: got %h expected %h", RFDP_Qj, 9'd9); end
    checks++;
    if (RFDP_Vj !== 32'hAA) begin errors++; $display("[TB] FAIL stale_value_vj: got %h expected aa", RFDP_Vj); end
  endtask

  task automatic test_same_cycle();
    idle();
    issue(6'd8, 8'd4);
    tick();
    idle();
    commit(6'd8, 8'd4, 32'h55);
    issue(6'd8, 8'd10);
    DPRF_rs1 = 6'd8;
    #1;
    checks++;
    if (RFDP_Vj !== 32'h55 || RFDP_Qj !== NON_DEP) begin
      errors++; $display("[TB] FAIL same_cycle_bypass: got q=%h v=%h expected q=%h v=55", RFDP_Qj, RFDP_Vj, NON_DEP);
    end
    tick();
    idle();
    DPRF_rs1 = 6'd8;
    #1;
    checks++;
    if (RFDP_Qj !== 9'd10) begin errors++; $display("[TB] FAIL issue_wins_qj: got %h expected %h", RFDP_Qj, 9'd10); end
    checks++;
    if (RFDP_Vj !== 32'h55) begin errors++; $display("[TB] FAIL issue_wins_vj: got %h expected 55", RFDP_Vj); end
    commit(6'd8, 8'd10, 32'h66);
    tick();
    idle();
    DPRF_rs1 = 6'd8;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP || RFDP_Vj !== 32'h66) begin
      errors++; $display("[TB] FAIL second_commit: got q=%h v=%h expected q=%h v=66", RFDP_Qj, RFDP_Vj, NON_DEP);
    end
  endtask

  task automatic test_flush();
    logic [31:0] expected [1:4];
    expected[1] = 32'h11;
    expected[2] = 32'h12;
    expected[3] = 32'h77;
    expected[4] = 32'h14;
    idle();
    for (int r = 1; r <= 4; r++) begin
      commit(6'(r), 8'd0, 32'h10 + 32'(r));
      tick();
    end
    idle();
    for (int r = 1; r <= 3; r++) begin
      issue(6'(r), 8'(r));
      tick();
    end
    idle();
    // Flush cycle: rename of x4 is dropped, commit to x3 still writes.
    RoBRF_pre_judge = 1'b0;
    issue(6'd4, 8'd4);
    commit(6'd3, 8'd3, 32'h77);
    DPRF_rs1 = 6'd1;
    DPRF_rs2 = 6'd2;
    #1;
    checks++;
    if (RFDP_Qj !== 9'd1) begin errors++; $display("[TB] FAIL flush_read_ignores_qj: got %h expected %h", RFDP_Qj, 9'd1); end
    checks++;
    if (RFDP_Qk !== 9'd2) begin errors++; $display("[TB] FAIL flush_read_ignores_qk: got %h expected %h", RFDP_Qk, 9'd2); end
    tick();
    idle();
    for (int r = 1; r <= 4; r++) begin
      DPRF_rs1 = 6'(r);
      DPRF_rs2 = 6'(r);
      #1;
      checks++;
      if (RFDP_Qj !== NON_DEP || RFDP_Vj !== expected[r]) begin
        errors++; $display("[TB] FAIL flush_x%0d_j: got q=%h v=%h expected q=%h v=%h", r, RFDP_Qj, RFDP_Vj, NON_DEP, expected[r]);
      end
      checks++;
      if (RFDP_Qk !== NON_DEP || RFDP_Vk !== expected[r]) begin
        errors++; $display("[TB] FAIL flush_x%0d_k: got q=%h v=%h expected q=%h v=%h", r, RFDP_Qk, RFDP_Vk, NON_DEP, expected[r]);
      end
    end
  endtask

  task automatic test_x0_and_stall();
    idle();
    commit(6'd0, 8'd5, 32'hFFFF);
    issue(6'd0, 8'd5);
    tick();
    idle();
    DPRF_rs1 = 6'd0;
    DPRF_rs2 = 6'd0;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP || RFDP_Vj !== 32'd0) begin
      errors++; $display("[TB] FAIL x0_j: got q=%h v=%h expected q=%h v=0", RFDP_Qj, RFDP_Vj, NON_DEP);
    end
    checks++;
    if (RFDP_Qk !== NON_DEP || RFDP_Vk !== 32'd0) begin
      errors++; $display("[TB] FAIL x0_k: got q=%h v=%h expected q=%h v=0", RFDP_Qk, RFDP_Vk, NON_DEP);
    end
    Sys_rdy = 1'b0;
    commit(6'd2, 8'd0, 32'hBEEF);
    issue(6'd2, 8'd12);
    tick();
    tick();
    idle();
    DPRF_rs1 = 6'd2;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP || RFDP_Vj !== 32'h12) begin
      errors++; $display("[TB] FAIL stall_x2: got q=%h v=%h expected q=%h v=12", RFDP_Qj, RFDP_Vj, NON_DEP);
    end
  endtask

  task automatic test_reset_midop();
    idle();
    Sys_rst = 1'b1;
    issue(6'd9, 8'd3);
    commit(6'd2, 8'd0, 32'hCAFE);
    tick();
    idle();
    DPRF_rs1 = 6'd9;
    DPRF_rs2 = 6'd2;
    #1;
    checks++;
    if (RFDP_Qj !== NON_DEP || RFDP_Vj !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_drops_issue: got q=%h v=%h expected q=%h v=0", RFDP_Qj, RFDP_Vj, NON_DEP);
    end
    checks++;
    if (RFDP_Qk !== NON_DEP || RFDP_Vk !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_drops_commit: got q=%h v=%h expected q=%h v=0", RFDP_Qk, RFDP_Vk, NON_DEP);
    end
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    idle();
    Sys_rst = 1'b1;
    tick();
    tick();
    Sys_rst = 1'b0;
    test_reset();
    test_issue_commit();
    test_newer_producer();
    test_same_cycle();
    test_flush();
    test_x0_and_stall();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
